// File: rtl/spi_module.sv
// ============================================================================
// Module   : spi_module
// Brief    : 8-bit write-only SPI master (mode 0, MSB first), registered outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_module #(
  parameter int CLK_DIV = 4
) (
  input  logic       SCLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       SPI_CLK,
  output logic       MOSI,
  output logic       SS,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SCK_HIGH = 3'd2,
    SCK_LOW  = 3'd3,
    TRAIL    = 3'd4
  } state_t;

  localparam logic [7:0] c_PHASE_LAST = 8'(CLK_DIV - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_phase, w_phase_nxt;
  logic [2:0] r_bits,  w_bits_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_spi_clk, w_spi_clk_nxt;
  logic       r_mosi,    w_mosi_nxt;
  logic       r_ss,      w_ss_nxt;
  logic       r_busy,    w_busy_nxt;
  logic       r_done,    w_done_nxt;
  logic       w_phase_end;

  assign w_phase_end = (r_phase == c_PHASE_LAST);

  always_ff @(posedge SCLK) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_phase   <= 8'd0;
      r_bits    <= 3'd0;
      r_shift   <= 8'd0;
      r_spi_clk <= 1'b0;
      r_mosi    <= 1'b0;
      r_ss      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_bits    <= w_bits_nxt;
      r_shift   <= w_shift_nxt;
      r_spi_clk <= w_spi_clk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_ss      <= w_ss_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_bits_nxt    = r_bits;
    w_shift_nxt   = r_shift;
    w_spi_clk_nxt = r_spi_clk;
    w_mosi_nxt    = r_mosi;
    w_ss_nxt      = r_ss;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;

    if (r_state != IDLE) begin
      w_phase_nxt = w_phase_end ? 8'd0 : r_phase + 8'd1;
    end

    case (r_state)
      IDLE: begin
        w_phase_nxt = 8'd0;
        // The done cycle is still part of the transfer, so a start there is dropped.
        if (start && !r_done) begin
          w_shift_nxt = data;
          w_bits_nxt  = 3'd7;
          w_mosi_nxt  = data[7];
          w_ss_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (w_phase_end) begin
          w_state_nxt   = SCK_HIGH;
          w_spi_clk_nxt = 1'b1;
        end
      end
      SCK_HIGH: begin
        if (w_phase_end) begin
          w_spi_clk_nxt = 1'b0;
          if (r_bits != 3'd0) begin
            w_state_nxt = SCK_LOW;
            w_bits_nxt  = r_bits - 3'd1;
            w_shift_nxt = {r_shift[6:0], 1'b0};
            w_mosi_nxt  = r_shift[6];
          end else begin
            w_state_nxt = TRAIL;
          end
        end
      end
      SCK_LOW: begin
        if (w_phase_end) begin
          w_state_nxt   = SCK_HIGH;
          w_spi_clk_nxt = 1'b1;
        end
      end
      TRAIL: begin
        if (w_phase_end) begin
          w_state_nxt = IDLE;
          w_ss_nxt    = 1'b1;
          w_busy_nxt  = 1'b0;
          w_mosi_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign SPI_CLK = r_spi_clk;
  assign MOSI    = r_mosi;
  assign SS      = r_ss;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_spi_module.sv
// ============================================================================
// Module   : tb_spi_module
// Brief    : Scoreboard bench for spi_module: CLK_DIV=4 and CLK_DIV=1 instances.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_module;

  typedef struct {
    logic [7:0] d;
    bit         abort;
    int         gap;   // expected SS-high cycles before this window, 0 = any
  } exp_t;

  logic       SCLK = 1'b0;
  logic       reset [2];
  logic       start [2];
  logic [7:0] data  [2];
  logic       spi_clk [2];
  logic       mosi    [2];
  logic       ss      [2];
  logic       busy    [2];
  logic       done    [2];

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q [2][$];
  bit   mon_en = 1'b0;

  logic       p_ss [2], p_clk [2], p_mosi [2], p_done [2];
  logic [7:0] cap [2];
  int         edges [2], lowlen [2], gap [2], last_rise [2];

  always #5 SCLK = ~SCLK;

  spi_module #(.CLK_DIV(4)) dut0 (
    .SCLK(SCLK), .reset(reset[0]), .start(start[0]), .data(data[0]),
    .SPI_CLK(spi_clk[0]), .MOSI(mosi[0]), .SS(ss[0]), .busy(busy[0]), .done(done[0])
  );

  spi_module #(.CLK_DIV(1)) dut1 (
    .SCLK(SCLK), .reset(reset[1]), .start(start[1]), .data(data[1]),
    .SPI_CLK(spi_clk[1]), .MOSI(mosi[1]), .SS(ss[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int div_of(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic void chk(string nm, int i, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0d (0x%0h), expected %0d (0x%0h)",
               nm, i, $time, act, act, exp, exp);
    end
  endfunction

  // Monitor: reconstructs each SS-low window as a slave would and scores it.
  always @(negedge SCLK) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (!ss[i] && p_ss[i]) begin
          if (q[i].size() == 0) begin
            chk("unexpected_transfer", i, 1, 0);
          end else if (q[i][0].gap != 0) begin
            chk("ss_gap", i, gap[i], q[i][0].gap);
          end
          edges[i] = 0; lowlen[i] = 0; cap[i] = 8'h00; last_rise[i] = 0;
        end
        if (!ss[i]) begin
          lowlen[i]++;
          if (spi_clk[i] && !p_clk[i]) begin
            if (edges[i] > 0) chk("sck_period", i, lowlen[i] - last_rise[i], 2 * div_of(i));
            last_rise[i] = lowlen[i];
            edges[i]++;
            cap[i] = {cap[i][6:0], mosi[i]};
          end
          if (spi_clk[i] && p_clk[i] && (mosi[i] != p_mosi[i]))
            chk("mosi_stable_high", i, int'(mosi[i]), int'(p_mosi[i]));
        end else begin
          if (spi_clk[i]) chk("sck_idle_when_ss_high", i, 1, 0);
          if (p_ss[i]) begin
            gap[i]++;
            if (done[i]) chk("stray_done", i, 1, 0);
          end
        end
        if (done[i] && p_done[i]) chk("done_width", i, 2, 1);
        if (ss[i] && !p_ss[i]) begin
          gap[i] = 1;
          if (q[i].size() == 0) begin
            chk("window_without_expect", i, 1, 0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            chk("busy_at_end", i, int'(busy[i]), 0);
            if (e.abort) begin
              chk("abort_no_done", i, int'(done[i]), 0);
            end else begin
              chk("rx_byte", i, int'(cap[i]), int'(e.d));
              chk("rise_edges", i, edges[i], 8);
              chk("ss_low_len", i, lowlen[i], 17 * div_of(i));
              chk("done_at_end", i, int'(done[i]), 1);
            end
          end
        end
        p_ss[i] = ss[i]; p_clk[i] = spi_clk[i]; p_mosi[i] = mosi[i]; p_done[i] = done[i];
      end
    end
  end

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while ((busy[i] || done[i]) && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) chk("wait_idle_timeout", i, 1, 0);
  endtask

  task automatic xfer(int i, logic [7:0] d, bit mess, int g);
    wait_idle(i);
    data[i]  = d;
    start[i] = 1'b1;
    q[i].push_back('{d: d, abort: 1'b0, gap: g});
    tick();
    start[i] = 1'b0;
    if (mess) begin
      for (int k = 0; k < 6; k++) begin
        repeat ($urandom_range(1, 6)) tick();
        start[i] = 1'($urandom_range(0, 1));
        data[i]  = 8'($urandom);
      end
      tick();
      start[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  initial begin
    int cnt, n;
    logic prev;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b0; start[i] = 1'b1; data[i] = 8'($urandom);
      p_ss[i] = 1'b1; p_clk[i] = 1'b0; p_mosi[i] = 1'b0; p_done[i] = 1'b0;
      cap[i] = 8'h00; edges[i] = 0; lowlen[i] = 0; gap[i] = 0; last_rise[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ss", i, int'(ss[i]), 1);
      chk("rst_sck", i, int'(spi_clk[i]), 0);
      chk("rst_mosi", i, int'(mosi[i]), 0);
      chk("rst_busy", i, int'(busy[i]), 0);
      chk("rst_done", i, int'(done[i]), 0);
      start[i] = 1'b0;
      reset[i] = 1'b1;
    end
    mon_en = 1'b1;
    tick();

    xfer(0, 8'hD4, 1'b0, 0);
    xfer(0, 8'hAA, 1'b0, 2);
    xfer(0, 8'h0F, 1'b0, 2);
    xfer(0, 8'hFF, 1'b0, 2);
    xfer(0, 8'($urandom), 1'b1, 2);
    xfer(0, 8'($urandom), 1'b1, 2);

    // Abort at the third SPI_CLK high, then a transfer on the first edge after release.
    wait_idle(0);
    data[0] = 8'($urandom); start[0] = 1'b1;
    q[0].push_back('{d: data[0], abort: 1'b1, gap: 0});
    tick();
    start[0] = 1'b0;
    cnt = 0; n = 0;
    while (cnt < 3 && n < 500) begin
      prev = spi_clk[0];
      tick();
      if (spi_clk[0] && !prev) cnt++;
      n++;
    end
    chk("third_high_seen", 0, cnt, 3);
    reset[0] = 1'b0; start[0] = 1'b1; data[0] = 8'hA3;
    tick();
    chk("abort_ss", 0, int'(ss[0]), 1);
    chk("abort_sck", 0, int'(spi_clk[0]), 0);
    chk("abort_busy", 0, int'(busy[0]), 0);
    reset[0] = 1'b1; data[0] = 8'h55;
    q[0].push_back('{d: 8'h55, abort: 1'b0, gap: 0});
    tick();
    start[0] = 1'b0;
    chk("accept_after_reset", 0, int'(busy[0]), 1);

    // Start held high across two transfers.
    wait_idle(0);
    data[0] = 8'h81; start[0] = 1'b1;
    q[0].push_back('{d: 8'h81, abort: 1'b0, gap: 0});
    q[0].push_back('{d: 8'h7E, abort: 1'b0, gap: 2});
    tick();
    data[0] = 8'h7E;
    n = 0;
    while (!done[0] && n < 500) begin tick(); n++; end
    while (!busy[0] && n < 500) begin tick(); n++; end
    chk("held_start_restart", 0, int'(busy[0]), 1);
    start[0] = 1'b0;

    for (int k = 0; k < 4; k++) xfer(0, 8'($urandom), 1'($urandom_range(0, 1)), 0);

    xfer(1, 8'h3C, 1'b0, 0);
    for (int k = 0; k < 5; k++) xfer(1, 8'($urandom), 1'b0, 2);

    wait_idle(0);
    wait_idle(1);
    repeat (40) tick();
    chk("queue_drained", 0, q[0].size(), 0);
    chk("queue_drained", 1, q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
